// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache with a pipelined 8-word block refill.
// Define ICACHE_PERF_CNT_EN to add saturating hit/miss counter outputs.
module icache #(
  parameter int SETS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req_addr,
  input  logic        req_valid,
  input  logic        flush,
  output logic [15:0] instr,
  output logic        stall,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_data,
  input  logic        mem_valid
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
`endif
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 12 - IDX_W;

  typedef enum logic {IDLE, FILL} state_t;
  state_t r_state, w_nextState;

  logic [15:0]      r_data [SETS*8];
  logic [TAG_W-1:0] r_tag  [SETS];
  logic [SETS-1:0]  r_valid;
  logic [TAG_W-1:0] r_fillTag;
  logic [IDX_W-1:0] r_fillIdx;
  logic [3:0]       r_issCnt;
  logic [2:0]       r_rcvCnt;
  logic             r_flushPend;

  logic [2:0]       w_off;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic             w_miss;
  logic             w_lastWord;
  logic             w_unusedByteBit;

  assign w_off           = req_addr[3:1];
  assign w_idx           = req_addr[3+IDX_W:4];
  assign w_tag           = req_addr[15:4+IDX_W];
  assign w_unusedByteBit = req_addr[0];

  assign w_hit      = (r_state == IDLE) && req_valid && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_miss     = (r_state == IDLE) && req_valid && !w_hit;
  assign w_lastWord = (r_state == FILL) && mem_valid && (r_rcvCnt == 3'd7);
  assign instr      = w_hit ? r_data[{w_idx, w_off}] : 16'h0000;

  always_comb begin
    w_nextState = r_state;
    stall       = 1'b0;
    mem_rd      = 1'b0;
    mem_addr    = 16'h0000;
    case (r_state)
      IDLE: begin
        if (w_miss) begin
          stall       = 1'b1;
          w_nextState = FILL;
        end
      end
      FILL: begin
        stall = 1'b1;
        // Bit 3 of the issue counter marks that all eight reads are already out.
        if (!r_issCnt[3]) begin
          mem_rd   = 1'b1;
          mem_addr = {r_fillTag, r_fillIdx, r_issCnt[2:0], 1'b0};
        end
        if (w_lastWord) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_issCnt    <= 4'd0;
      r_rcvCnt    <= 3'd0;
      r_flushPend <= 1'b0;
      r_valid     <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == IDLE) begin
        r_issCnt    <= 4'd0;
        r_rcvCnt    <= 3'd0;
        r_flushPend <= 1'b0;
        if (flush) r_valid <= '0;
      end else begin
        if (!r_issCnt[3]) r_issCnt <= r_issCnt + 4'd1;
        if (mem_valid) r_rcvCnt <= r_rcvCnt + 3'd1;
        r_flushPend <= r_flushPend | flush;
        // A flush seen at any point of the fill also discards the line just filled.
        if (w_lastWord) begin
          r_flushPend <= 1'b0;
          if (r_flushPend || flush) r_valid <= '0;
          else r_valid[r_fillIdx] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_miss) begin
      r_fillTag <= w_tag;
      r_fillIdx <= w_idx;
    end
    if ((r_state == FILL) && mem_valid) r_data[{r_fillIdx, r_rcvCnt}] <= mem_data;
    if (w_lastWord) r_tag[r_fillIdx] <= r_fillTag;
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [15:0] r_hitCnt;
  logic [15:0] r_missCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hitCnt  <= 16'd0;
      r_missCnt <= 16'd0;
    end else begin
      if (w_hit && (r_hitCnt != 16'hFFFF)) r_hitCnt <= r_hitCnt + 16'd1;
      if (w_miss && (r_missCnt != 16'hFFFF)) r_missCnt <= r_missCnt + 16'd1;
    end
  end

  assign hit_cnt  = r_hitCnt;
  assign miss_cnt = r_missCnt;
`endif

endmodule

// File: tb/tb_icache.sv
// tb_icache: scenario-based self-checking bench for icache with a latency-4 pipelined memory model.
// Expected read addresses are queued when a fill is provoked and popped against observed reads.
module tb_icache;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic        req_valid = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] instr;
  logic        stall;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_data;
  logic        mem_valid;
`ifdef ICACHE_PERF_CNT_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  int checks = 0;
  int passes = 0;
  logic [15:0] expAddr[$];
  logic [15:0] obsAddr[$];

  icache #(.SETS(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_addr(req_addr), .req_valid(req_valid), .flush(flush),
    .instr(instr), .stall(stall), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_data(mem_data), .mem_valid(mem_valid)
`ifdef ICACHE_PERF_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory answers each read four cycles later with data = address + 16'h1000.
  logic        pipeV [4];
  logic [15:0] pipeD [4];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        pipeV[i] <= 1'b0;
        pipeD[i] <= 16'h0000;
      end
    end else begin
      pipeV[0] <= mem_rd;
      pipeD[0] <= mem_addr + 16'h1000;
      for (int i = 1; i < 4; i++) begin
        pipeV[i] <= pipeV[i-1];
        pipeD[i] <= pipeD[i-1];
      end
    end
  end
  assign mem_valid = pipeV[3];
  assign mem_data  = pipeD[3];

  task automatic resetDut();
    rst_n = 1'b0;
    req_valid = 1'b0;
    flush = 1'b0;
    req_addr = 16'h0000;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    expAddr.delete();
    obsAddr.delete();
  endtask

  task automatic pushFill(input logic [15:0] addr);
    for (int k = 0; k < 8; k++) expAddr.push_back({addr[15:4], k[2:0], 1'b0});
  endtask

  task automatic stepCycle(output logic sStall, output logic [15:0] sInstr);
    @(negedge clk);
    sStall = stall;
    sInstr = instr;
    if (mem_rd === 1'b1) obsAddr.push_back(mem_addr);
    @(posedge clk);
    #1;
  endtask

  task automatic runRequest(input logic [15:0] addr, output int nStall, output logic [15:0] got);
    logic s;
    logic [15:0] w;
    req_addr = addr;
    req_valid = 1'b1;
    nStall = 0;
    stepCycle(s, w);
    while (s === 1'b1 && nStall < 100) begin
      nStall++;
      stepCycle(s, w);
    end
    got = w;
    req_valid = 1'b0;
  endtask

  task automatic probe(input logic [15:0] addr, input logic fl, output logic s, output logic [15:0] got);
    req_addr = addr;
    req_valid = 1'b1;
    flush = fl;
    stepCycle(s, got);
    req_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    resetDut();
    checks++; if (stall !== 1'b0) $display("[TB] FAIL reset_stall got=%b want=0", stall); else passes++;
    checks++; if (mem_rd !== 1'b0) $display("[TB] FAIL reset_mem_rd got=%b want=0", mem_rd); else passes++;
    checks++; if (mem_addr !== 16'h0000) $display("[TB] FAIL reset_mem_addr got=%h want=0000", mem_addr); else passes++;
    checks++; if (instr !== 16'h0000) $display("[TB] FAIL reset_instr got=%h want=0000", instr); else passes++;
  endtask

  task automatic test_cold_miss();
    int n;
    logic s;
    logic [15:0] got, e, o;
    resetDut();
    pushFill(16'h0000);
    runRequest(16'h0000, n, got);
    checks++; if (n !== 13) $display("[TB] FAIL cold_stall_cycles got=%0d want=13", n); else passes++;
    checks++; if (got !== 16'h1000) $display("[TB] FAIL cold_instr got=%h want=1000", got); else passes++;
    checks++; if (obsAddr.size() !== 8) $display("[TB] FAIL cold_read_count got=%0d want=8", obsAddr.size()); else passes++;
    while (expAddr.size() > 0 && obsAddr.size() > 0) begin
      e = expAddr.pop_front();
      o = obsAddr.pop_front();
      checks++; if (o !== e) $display("[TB] FAIL cold_mem_addr got=%h want=%h", o, e); else passes++;
    end
    probe(16'h000E, 1'b0, s, got);
    checks++; if (s !== 1'b0) $display("[TB] FAIL cold_hit_stall got=%b want=0", s); else passes++;
    checks++; if (got !== 16'h100E) $display("[TB] FAIL cold_hit_instr got=%h want=100E", got); else passes++;
    checks++; if (obsAddr.size() !== 0) $display("[TB] FAIL cold_hit_reads got=%0d want=0", obsAddr.size()); else passes++;
  endtask

  task automatic test_conflict();
    int n;
    logic [15:0] got;
    resetDut();
    pushFill(16'h0000);
    runRequest(16'h0000, n, got);
    pushFill(16'h0200);
    runRequest(16'h0200, n, got);
    checks++; if (n !== 13) $display("[TB] FAIL conflict_miss_stall got=%0d want=13", n); else passes++;
    checks++; if (got !== 16'h1200) $display("[TB] FAIL conflict_instr got=%h want=1200", got); else passes++;
    pushFill(16'h0000);
    runRequest(16'h0004, n, got);
    checks++; if (n !== 13) $display("[TB] FAIL conflict_return_stall got=%0d want=13", n); else passes++;
    checks++; if (got !== 16'h1004) $display("[TB] FAIL conflict_return_instr got=%h want=1004", got); else passes++;
    checks++; if (obsAddr.size() !== 24) $display("[TB] FAIL conflict_reads got=%0d want=24", obsAddr.size()); else passes++;
    while (expAddr.size() > 0 && obsAddr.size() > 0) begin
      checks++;
      if (obsAddr[0] !== expAddr[0]) $display("[TB] FAIL conflict_mem_addr got=%h want=%h", obsAddr[0], expAddr[0]);
      else passes++;
      void'(obsAddr.pop_front());
      void'(expAddr.pop_front());
    end
  endtask

  task automatic test_flush();
    int n;
    logic s;
    logic [15:0] got;
    resetDut();
    pushFill(16'h0100);
    req_addr = 16'h0106;
    req_valid = 1'b1;
    stepCycle(s, got);
    req_valid = 1'b0;
    repeat (2) stepCycle(s, got);
    flush = 1'b1;
    stepCycle(s, got);
    flush = 1'b0;
    n = 0;
    while (s === 1'b1 && n < 100) begin
      n++;
      stepCycle(s, got);
    end
    checks++; if (obsAddr.size() !== 8) $display("[TB] FAIL flush_fill_reads got=%0d want=8", obsAddr.size()); else passes++;
    while (expAddr.size() > 0 && obsAddr.size() > 0) begin
      checks++;
      if (obsAddr[0] !== expAddr[0]) $display("[TB] FAIL flush_mem_addr got=%h want=%h", obsAddr[0], expAddr[0]);
      else passes++;
      void'(obsAddr.pop_front());
      void'(expAddr.pop_front());
    end
    pushFill(16'h0100);
    runRequest(16'h0106, n, got);
    checks++; if (n !== 13) $display("[TB] FAIL flush_refill_stall got=%0d want=13", n); else passes++;
    checks++; if (got !== 16'h1106) $display("[TB] FAIL flush_refill_instr got=%h want=1106", got); else passes++;
    // The lookup in the flushing cycle still sees the line as valid.
    probe(16'h0108, 1'b1, s, got);
    checks++; if (s !== 1'b0) $display("[TB] FAIL flush_same_cycle_stall got=%b want=0", s); else passes++;
    checks++; if (got !== 16'h1108) $display("[TB] FAIL flush_same_cycle_instr got=%h want=1108", got); else passes++;
    pushFill(16'h0100);
    runRequest(16'h0108, n, got);
    checks++; if (n !== 13) $display("[TB] FAIL flush_idle_miss got=%0d want=13", n); else passes++;
    checks++; if (obsAddr.size() !== 16) $display("[TB] FAIL flush_total_reads got=%0d want=16", obsAddr.size()); else passes++;
  endtask

  task automatic test_reset_mid_fill();
    int n;
    logic s;
    logic [15:0] got;
    resetDut();
    pushFill(16'h0040);
    req_addr = 16'h0040;
    req_valid = 1'b1;
    stepCycle(s, got);
    req_valid = 1'b0;
    repeat (4) stepCycle(s, got);
    rst_n = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) $display("[TB] FAIL rstfill_stall got=%b want=0", stall); else passes++;
    checks++; if (mem_rd !== 1'b0) $display("[TB] FAIL rstfill_mem_rd got=%b want=0", mem_rd); else passes++;
    checks++; if (obsAddr.size() !== 4) $display("[TB] FAIL rstfill_partial_reads got=%0d want=4", obsAddr.size()); else passes++;
    expAddr.delete();
    obsAddr.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pushFill(16'h0040);
    runRequest(16'h0042, n, got);
    checks++; if (n !== 13) $display("[TB] FAIL rstfill_remiss got=%0d want=13", n); else passes++;
    checks++; if (got !== 16'h1042) $display("[TB] FAIL rstfill_instr got=%h want=1042", got); else passes++;
    checks++; if (obsAddr.size() !== 8) $display("[TB] FAIL rstfill_reads got=%0d want=8", obsAddr.size()); else passes++;
  endtask

  task automatic test_addr_toggle();
    int n;
    logic s;
    logic [15:0] got;
    resetDut();
    pushFill(16'h0020);
    req_addr = 16'h0020;
    req_valid = 1'b1;
    stepCycle(s, got);
    n = (s === 1'b1) ? 1 : 0;
    for (int c = 0; c < 10; c++) begin
      req_addr = 16'($urandom);
      req_valid = 1'($urandom_range(0, 1));
      stepCycle(s, got);
      if (s === 1'b1) n++;
    end
    req_valid = 1'b0;
    stepCycle(s, got);
    while (s === 1'b1 && n < 100) begin
      n++;
      stepCycle(s, got);
    end
    checks++; if (n !== 13) $display("[TB] FAIL toggle_stall got=%0d want=13", n); else passes++;
    checks++; if (obsAddr.size() !== 8) $display("[TB] FAIL toggle_reads got=%0d want=8", obsAddr.size()); else passes++;
    while (expAddr.size() > 0 && obsAddr.size() > 0) begin
      checks++;
      if (obsAddr[0] !== expAddr[0]) $display("[TB] FAIL toggle_mem_addr got=%h want=%h", obsAddr[0], expAddr[0]);
      else passes++;
      void'(obsAddr.pop_front());
      void'(expAddr.pop_front());
    end
    probe(16'h002A, 1'b0, s, got);
    checks++; if (got !== 16'h102A) $display("[TB] FAIL toggle_hit_instr got=%h want=102A", got); else passes++;
  endtask

`ifdef ICACHE_PERF_CNT_EN
  task automatic test_perf_counters();
    int n;
    logic s;
    logic [15:0] got;
    resetDut();
    checks++; if (hit_cnt !== 16'd0) $display("[TB] FAIL perf_reset_hits got=%0d want=0", hit_cnt); else passes++;
    pushFill(16'h0030);
    // The request's final cycle is itself an IDLE hit, so nine probes make ten hits.
    runRequest(16'h0030, n, got);
    for (int k = 0; k < 9; k++) probe(16'h0030 | 16'((k % 8) * 2), 1'b0, s, got);
    checks++; if (miss_cnt !== 16'd1) $display("[TB] FAIL perf_miss_cnt got=%0d want=1", miss_cnt); else passes++;
    checks++; if (hit_cnt !== 16'd10) $display("[TB] FAIL perf_hit_cnt got=%0d want=10", hit_cnt); else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_cold_miss();
    test_conflict();
    test_flush();
    test_reset_mid_fill();
    test_addr_toggle();
`ifdef ICACHE_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog_timeout got=running want=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
